alu_addsub16: RTL and testbench
===============================

// Module: alu_addsub16
// PURPOSE
//   Registered 16-bit two's-complement adder/subtractor with condition flags.
//   M selects A+B (M=0) or A-B (M=1).
//   Produces result S, carry-out, and N/Z/C/V flags for downstream branch/status logic.
//   Sits in the datapath execute stage; all outputs are registered on clk.
// PARAMETERS
//   WIDTH  16  operand/result width in bits; the flag rules below use MSB = WIDTH-1
// PORTS
//   clk   in   1      single clock, rising edge
//   rst   in   1      synchronous, active-high reset
//   A     in   WIDTH  operand A
//   B     in   WIDTH  operand B
//   M     in   1      mode: 0 = add, 1 = subtract
//   S     out  WIDTH  registered result
//   cout  out  1      registered carry out of the MSB
//   N     out  1      negative flag
//   Z     out  1      zero flag
//   C     out  1      carry flag
//   V     out  1      signed-overflow flag
// BEHAVIOUR
//   - Interface: one clock, clk; reset rst is synchronous and active-high.
//   - Core sum = A + (B ^ {WIDTH{M}}) + M, computed (WIDTH+1) bits wide.
//   - Subtraction is A + ~B + 1; no separate subtractor.
//   - cout = bit WIDTH of the core sum.
//   - C = cout in both modes; for subtract, C=1 means no borrow (A >= B unsigned).
//   - V = (A[MSB] == Bx[MSB]) && (sum[MSB] != A[MSB]), where Bx = B ^ {WIDTH{M}}.
//   - N = S[MSB] of the value written to S.
//   - Z = (S == 0) of the value written to S.
//   - Latency: 1 cycle. Inputs sampled at edge k appear on all outputs after edge k.
//   - No handshake; a new operation is accepted every cycle.
//   - Outputs hold their value until the next edge.
//   - Reset: when rst=1 at a rising edge, S=0, cout=0, N=0, Z=0, C=0, V=0.
//     Z is deliberately 0 at reset: the flags are "no operation yet".
//   - rst has priority over any concurrent operation.
//     Reset mid-stream discards that cycle's inputs.
//     The first operation after rst deasserts completes normally one cycle later.
//   - Wrap-around: results are modulo 2^WIDTH unless ALU_SAT_EN is defined.
//   - No X-propagation guards required; inputs are assumed driven.
// CONFIGURATION
//   Macro ALU_SAT_EN
//   - Defined: signed saturation. On V=1, S clamps to 0x7FFF if A[MSB]=0, else 0x8000.
//     V, C and cout still report the unclamped operation.
//     N and Z follow the clamped S.
//   - Undefined: S is always the wrapped sum; no saturation logic is built.
// STRUCTURE
//   - Package alu_pkg:
//     - localparam ALU_WIDTH = 16
//     - mode constants ALU_ADD = 1'b0, ALU_SUB = 1'b1
//     - typedef alu_flags_t {N, Z, C, V}
//   - One sub-module, alu_ripple_adder: WIDTH-bit ripple-carry adder.
//     Inputs a, b, cin; outputs sum and carry-out.
//     Built from a generate loop of full-adder bit cells.
//   - Top level provides the B-invert XOR, the overflow/flag logic,
//     optional saturation, and the output registers.
// TESTING
//   1. A=0x1234, B=0x4321, M=0 -> next cycle S=0x5555 (21845), cout=C=0, N=0, Z=0, V=0.
//   2. A=0x1234, B=0x4321, M=1 -> S=0xCF13, cout=C=0 (borrow), N=1, Z=0, V=0.
//   3. A=0x7FFF, B=0x0001, M=0 -> S=0x8000, V=1, N=1, C=0.
//      With ALU_SAT_EN: S=0x7FFF, N=0, V=1.
//   4. A=0xFFFF, B=0x0001, M=0 -> S=0x0000, Z=1, C=cout=1, V=0, N=0.
//      Then A=0x8000, B=0x0001, M=1 -> S=0x7FFF, V=1, C=1.
//   5. Drive rst=1 while A=0x1234, B=0x4321, M=0 -> all outputs 0 after the edge.
//      Deassert rst -> S=0x5555 one cycle later.
//   6. Back-to-back: alternate M every cycle for 100 random A/B pairs.
//      Each output must match a reference model delayed one cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared width, mode encodings and flag bundle for the add/sub ALU
package alu_pkg;
  localparam int ALU_WIDTH = 16;
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;
endpackage

// File: rtl/alu_ripple_adder.sv
// alu_ripple_adder: WIDTH-bit ripple-carry adder built from full-adder bit cells
module alu_ripple_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[WIDTH];
endmodule

// File: rtl/alu_addsub16.sv
// alu_addsub16: registered add/sub with N/Z/C/V flags; define ALU_SAT_EN for signed saturation of S
import alu_pkg::*;
module alu_addsub16 #(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             M,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V
);
  logic [WIDTH-1:0] bx, sum, s_d, s_q;
  logic co, cout_d, cout_q, v;
  alu_flags_t flags_d, flags_q;
  assign bx = B ^ {WIDTH{M == ALU_SUB}};
  alu_ripple_adder #(.WIDTH(WIDTH)) u_add (
    .a   (A),
    .b   (bx),
    .cin (M),
    .sum (sum),
    .cout(co)
  );
  // overflow, optional clamp, and flags derived from the value actually written to S
  always_comb begin
    v = (A[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
`ifdef ALU_SAT_EN
    s_d = v ? {A[WIDTH-1], {(WIDTH-1){~A[WIDTH-1]}}} : sum;
`else
    s_d = sum;
`endif
    cout_d = co;
    flags_d = '{n: s_d[WIDTH-1], z: s_d == '0, c: co, v: v};
  end
  // output registers; reset clears everything, Z included, meaning no operation yet
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
      cout_q <= 1'b0;
      flags_q <= '0;
    end else begin
      s_q <= s_d;
      cout_q <= cout_d;
      flags_q <= flags_d;
    end
  end
  assign S = s_q;
  assign cout = cout_q;
  assign N = flags_q.n;
  assign Z = flags_q.z;
  assign C = flags_q.c;
  assign V = flags_q.v;
endmodule

// File: tb/tb_alu_addsub16.sv
// tb_alu_addsub16: directed table plus randomized checks against an arithmetic reference model
module tb_alu_addsub16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] a = '0, b = '0;
  logic m = 1'b0;
  logic [15:0] s;
  logic cout, n, z, c, v;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  alu_addsub16 dut (
    .clk (clk),
    .rst (rst),
    .A   (a),
    .B   (b),
    .M   (m),
    .S   (s),
    .cout(cout),
    .N   (n),
    .Z   (z),
    .C   (c),
    .V   (v)
  );
  typedef struct {
    string       name;
    logic        r;
    logic [15:0] a;
    logic [15:0] b;
    logic        m;
    logic [20:0] exp;
  } vec_t;
  function automatic logic [20:0] model(logic [15:0] ai, logic [15:0] bi, logic mi, logic ri);
    int sa, sb, sr, ur;
    logic [15:0] rs;
    logic rc, rv;
    if (ri) return '0;
    sa = $signed(ai);
    sb = $signed(bi);
    sr = mi ? sa - sb : sa + sb;
    ur = mi ? int'(ai) - int'(bi) : int'(ai) + int'(bi);
    rc = mi ? (ai >= bi) : (ur > 65535);
    rs = ur[15:0];
    rv = (sr > 32767) || (sr < -32768);
`ifdef ALU_SAT_EN
    if (rv) rs = (sa < 0) ? 16'h8000 : 16'h7FFF;
`endif
    return {rs, rc, rs[15], rs == 16'h0, rc, rv};
  endfunction
  task automatic step(string name, logic ri, logic [15:0] ai, logic [15:0] bi, logic mi, logic [20:0] exp);
    logic [20:0] got;
    rst = ri;
    a = ai;
    b = bi;
    m = mi;
    @(posedge clk);
    #1;
    got = {s, cout, n, z, c, v};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got S=%h cout/N/Z/C/V=%b, expected S=%h cout/N/Z/C/V=%b",
               name, got[20:5], got[4:0], exp[20:5], exp[4:0]);
    end
  endtask
  vec_t tbl[$];
  initial begin
    tbl.push_back('{"reset_state", 1'b1, 16'h0000, 16'h0000, 1'b0, {16'h0000, 5'b00000}});
    tbl.push_back('{"add_basic",   1'b0, 16'h1234, 16'h4321, 1'b0, {16'h5555, 5'b00000}});
    tbl.push_back('{"sub_borrow",  1'b0, 16'h1234, 16'h4321, 1'b1, {16'hCF13, 5'b01000}});
`ifdef ALU_SAT_EN
    tbl.push_back('{"add_pos_ovf", 1'b0, 16'h7FFF, 16'h0001, 1'b0, {16'h7FFF, 5'b00001}});
`else
    tbl.push_back('{"add_pos_ovf", 1'b0, 16'h7FFF, 16'h0001, 1'b0, {16'h8000, 5'b01001}});
`endif
    tbl.push_back('{"add_wrap_0",  1'b0, 16'hFFFF, 16'h0001, 1'b0, {16'h0000, 5'b10110}});
`ifdef ALU_SAT_EN
    tbl.push_back('{"sub_neg_ovf", 1'b0, 16'h8000, 16'h0001, 1'b1, {16'h8000, 5'b11011}});
    tbl.push_back('{"add_min_min", 1'b0, 16'h8000, 16'h8000, 1'b0, {16'h8000, 5'b11011}});
`else
    tbl.push_back('{"sub_neg_ovf", 1'b0, 16'h8000, 16'h0001, 1'b1, {16'h7FFF, 5'b10011}});
    tbl.push_back('{"add_min_min", 1'b0, 16'h8000, 16'h8000, 1'b0, {16'h0000, 5'b10111}});
`endif
    tbl.push_back('{"sub_zero",    1'b0, 16'h0000, 16'h0000, 1'b1, {16'h0000, 5'b10110}});
    tbl.push_back('{"sub_equal",   1'b0, 16'hA5A5, 16'hA5A5, 1'b1, {16'h0000, 5'b10110}});
    tbl.push_back('{"sub_1_m1",    1'b0, 16'h0001, 16'hFFFF, 1'b1, {16'h0002, 5'b00000}});
    tbl.push_back('{"pre_reset",   1'b0, 16'hFFFF, 16'hFFFF, 1'b0, {16'hFFFE, 5'b11010}});
    tbl.push_back('{"mid_reset",   1'b1, 16'h1234, 16'h4321, 1'b0, {16'h0000, 5'b00000}});
    tbl.push_back('{"post_reset",  1'b0, 16'h1234, 16'h4321, 1'b0, {16'h5555, 5'b00000}});
    step("init_reset", 1'b1, 16'h0, 16'h0, 1'b0, '0);
    foreach (tbl[i]) step(tbl[i].name, tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].exp);
    for (int i = 0; i < 100; i++) begin
      logic [15:0] ra, rb;
      logic rm;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rm = i[0];
      step("random_b2b", 1'b0, ra, rb, rm, model(ra, rb, rm, 1'b0));
    end
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      logic rm, rr;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rm = 1'($urandom);
      rr = ($urandom_range(0, 7) == 0);
      step("random_rst", rr, ra, rb, rm, model(ra, rb, rm, rr));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
